// File: rtl/down_counter_timer_if.sv
// Control/status bundle for down_counter_timer.
// The master side (sequencer or bench) drives the controls and the slave side
// (the timer) returns the count and the status flags.
interface down_counter_timer_if #(
  parameter int NBitsForCounter = 5
);
  logic                       enb;
  logic                       start;
  logic                       stop;
  logic                       mode;
  logic [NBitsForCounter-1:0] N_input;
  logic                       Flag;
  logic                       busy;
  logic                       done;
  logic [NBitsForCounter-1:0] Counting;

  modport master (
    output enb, start, stop, mode, N_input,
    input  Flag, busy, done, Counting
  );

  modport slave (
    input  enb, start, stop, mode, N_input,
    output Flag, busy, done, Counting
  );
endinterface

// File: rtl/down_counter_timer.sv
// Programmable down-counting interval timer with one-shot and periodic modes.
// A period is N_input+1 enabled cycles, and Flag marks the zero count.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | stopped, count held at 0, waiting for start
//   RUN   | counting down on enabled cycles, Flag at count 0
//   DONE  | one-shot expired, done=1, waiting for start
module down_counter_timer #(
  parameter int NBitsForCounter = 5
) (
  input logic                  clk,
  input logic                  rst,
  down_counter_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [NBitsForCounter-1:0] CNT_ZERO = '0;
  localparam logic [NBitsForCounter-1:0] CNT_ONE  = {{(NBitsForCounter-1){1'b0}}, 1'b1};

  state_t                     state, state_next;
  logic [NBitsForCounter-1:0] count, count_next;
  logic [NBitsForCounter-1:0] reload_reg, reload_next;
  logic                       mode_reg, mode_next;
  logic                       count_is_zero;

  assign count_is_zero = (count == CNT_ZERO);

  // Register the state, the count and the values latched at start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= CNT_ZERO;
      reload_reg <= CNT_ZERO;
      mode_reg   <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      reload_reg <= reload_next;
      mode_reg   <= mode_next;
    end
  end

  // Compute the next state and count, giving stop priority over start and start over counting.
  always_comb begin
    state_next  = state;
    count_next  = count;
    reload_next = reload_reg;
    mode_next   = mode_reg;

    if (bus.stop) begin
      state_next = IDLE;
      count_next = CNT_ZERO;
    end else if (bus.start) begin
      // Load or restart from any state. A restart in RUN ignores enb.
      state_next  = RUN;
      count_next  = bus.N_input;
      reload_next = bus.N_input;
      mode_next   = bus.mode;
    end else begin
      unique case (state)
        IDLE: begin
          count_next = CNT_ZERO;
        end
        RUN: begin
          if (bus.enb) begin
            if (!count_is_zero) begin
              count_next = count - CNT_ONE;
            end else if (mode_reg) begin
              count_next = reload_reg;
            end else begin
              // A count of 0 always reloads or finishes, so it never wraps.
              count_next = CNT_ZERO;
              state_next = DONE;
            end
          end
        end
        DONE: begin
          count_next = CNT_ZERO;
        end
        default: begin
          state_next = IDLE;
          count_next = CNT_ZERO;
        end
      endcase
    end
  end

  // Decode the outputs straight from the registered state and count.
  always_comb begin
    bus.Flag     = (state == RUN) && count_is_zero;
    bus.busy     = (state == RUN);
    bus.done     = (state == DONE);
    bus.Counting = count;
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer with hand-computed expectations.
module tb_down_counter_timer;

  localparam int W = 5;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  down_counter_timer_if #(.NBitsForCounter(W)) bus ();

  down_counter_timer #(.NBitsForCounter(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge, where both sampling and driving happen.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] cnt, input logic flag,
                         input logic busy, input logic done);
    chk({tag, ".cnt"},  32'(bus.Counting), 32'(cnt));
    chk({tag, ".flag"}, 32'(bus.Flag),     32'(flag));
    chk({tag, ".busy"}, 32'(bus.busy),     32'(busy));
    chk({tag, ".done"}, 32'(bus.done),     32'(done));
  endtask

  task automatic do_start(input logic [W-1:0] n, input logic m);
    bus.N_input = n;
    bus.mode    = m;
    bus.start   = 1'b1;
    step();
    bus.start   = 1'b0;
  endtask

  logic [W-1:0] per_cnt  [9] = '{5'd2, 5'd1, 5'd0, 5'd2, 5'd1, 5'd0, 5'd2, 5'd1, 5'd0};
  logic         per_flag [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bus.enb     = 1'b0;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.mode    = 1'b0;
    bus.N_input = '0;

    // Reset held for two cycles
    step();
    step();
    chk_all("reset", 5'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    chk_all("idle", 5'd0, 1'b0, 1'b0, 1'b0);

    // One-shot N=3
    bus.enb = 1'b1;
    do_start(5'd3, 1'b0);
    chk_all("os3.load", 5'd3, 1'b0, 1'b1, 1'b0);
    step(); chk_all("os3.c2", 5'd2, 1'b0, 1'b1, 1'b0);
    step(); chk_all("os3.c1", 5'd1, 1'b0, 1'b1, 1'b0);
    step(); chk_all("os3.c0", 5'd0, 1'b1, 1'b1, 1'b0);
    step(); chk_all("os3.done", 5'd0, 1'b0, 1'b0, 1'b1);
    step(); chk_all("os3.hold", 5'd0, 1'b0, 1'b0, 1'b1);

    // Periodic N=2, nine enabled cycles; the load cycle is the first one
    do_start(5'd2, 1'b1);
    for (int i = 0; i < 9; i++) begin
      if (i != 0) step();
      chk($sformatf("per2.cnt%0d", i + 1), 32'(bus.Counting), 32'(per_cnt[i]));
      chk($sformatf("per2.flag%0d", i + 1), 32'(bus.Flag), 32'(per_flag[i]));
    end

    // enb gating, periodic N=4
    do_start(5'd4, 1'b1);
    step(); chk("gate.c3", 32'(bus.Counting), 32'd3);
    step(); chk("gate.c2", 32'(bus.Counting), 32'd2);
    bus.enb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("gate.hold%0d", i), 5'd2, 1'b0, 1'b1, 1'b0);
    end
    bus.enb = 1'b1;
    step(); chk("gate.c1", 32'(bus.Counting), 32'd1);
    step(); chk_all("gate.c0", 5'd0, 1'b1, 1'b1, 1'b0);
    step(); chk("gate.reload", 32'(bus.Counting), 32'd4);

    // stop and start together while counting: stop wins
    step(); chk("abort.pre", 32'(bus.Counting), 32'd3);
    bus.stop    = 1'b1;
    bus.start   = 1'b1;
    bus.N_input = 5'd9;
    step();
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    chk_all("abort", 5'd0, 1'b0, 1'b0, 1'b0);
    step(); chk_all("abort.idle", 5'd0, 1'b0, 1'b0, 1'b0);

    // Restart at Counting=1 with enb low
    do_start(5'd5, 1'b1);
    for (int i = 0; i < 4; i++) step();
    chk("rst7.pre", 32'(bus.Counting), 32'd1);
    bus.enb = 1'b0;
    do_start(5'd7, 1'b1);
    chk_all("rst7.load", 5'd7, 1'b0, 1'b1, 1'b0);
    bus.enb = 1'b1;
    step(); chk("rst7.c6", 32'(bus.Counting), 32'd6);

    // N=0 periodic: Flag on every enabled cycle
    do_start(5'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk_all($sformatf("n0p.%0d", i), 5'd0, 1'b1, 1'b1, 1'b0);
      step();
    end

    // N=0 one-shot: one Flag cycle then DONE, then start again from DONE
    do_start(5'd0, 1'b0);
    chk_all("n0os.flag", 5'd0, 1'b1, 1'b1, 1'b0);
    step(); chk_all("n0os.done", 5'd0, 1'b0, 1'b0, 1'b1);
    do_start(5'd1, 1'b0);
    chk_all("done.restart", 5'd1, 1'b0, 1'b1, 1'b0);

    // Maximum load value
    do_start(5'd31, 1'b0);
    chk("max.load", 32'(bus.Counting), 32'd31);
    step(); chk("max.c30", 32'(bus.Counting), 32'd30);

    // Reset mid-count: no Flag afterwards, and a clean IDLE
    do_start(5'd3, 1'b1);
    rst = 1'b1;
    step();
    chk_all("midrst", 5'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step(); chk_all("midrst.idle", 5'd0, 1'b0, 1'b0, 1'b0);

    // Periodic mode must not persist through reset: a restart in one-shot expires
    do_start(5'd1, 1'b0);
    step(); step();
    chk_all("post.done", 5'd0, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
